// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: per-window mean |x|, peak, held peak with timed
// release, quiet-window noise floor and clip flag, published on a valid/ready handshake.
module audio_level_meter #(
    parameter int W            = 16,
    parameter int NUM_CH       = 2,
    parameter int LOG2_WIN     = 10,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                quiet_period,
    input  logic [NUM_CH*W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_CH*W-1:0] out_mean,
    output logic [NUM_CH*W-1:0] out_peak,
    output logic [NUM_CH*W-1:0] out_hold,
    output logic [NUM_CH*W-1:0] out_noise,
    output logic [NUM_CH-1:0]   out_clip,
    output logic                out_valid,
    input  logic                out_ready
);
    typedef enum logic {ACCUM = 1'b0, PUBLISH = 1'b1} state_e;

    localparam int SW  = W + LOG2_WIN;
    localparam int HCW = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
    localparam logic [W-1:0]   NEG_FS    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]   POS_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_WINDOWS - 1);

    state_e              state_q, state_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic                quiet_all_q, quiet_all_d;
    logic                out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]   clip_acc_q, clip_acc_d;
    logic [NUM_CH-1:0]   clip_q, clip_d;
    logic [SW-1:0]       sum_q      [NUM_CH];
    logic [SW-1:0]       sum_d      [NUM_CH];
    logic [W-1:0]        run_peak_q [NUM_CH];
    logic [W-1:0]        run_peak_d [NUM_CH];
    logic [W-1:0]        mean_q     [NUM_CH];
    logic [W-1:0]        mean_d     [NUM_CH];
    logic [W-1:0]        peak_q     [NUM_CH];
    logic [W-1:0]        peak_d     [NUM_CH];
    logic [W-1:0]        hold_q     [NUM_CH];
    logic [W-1:0]        hold_d     [NUM_CH];
    logic [W-1:0]        noise_q    [NUM_CH];
    logic [W-1:0]        noise_d    [NUM_CH];
    logic [HCW-1:0]      rel_q      [NUM_CH];
    logic [HCW-1:0]      rel_d      [NUM_CH];

    logic [W-1:0]        mag        [NUM_CH];
    logic [NUM_CH-1:0]   is_neg_fs;
    logic                accept;
    logic                last_beat;

    // Negative full scale has no positive twin, so it saturates and flags clipping.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            is_neg_fs[c] = (in_data[c*W +: W] == NEG_FS);
            if (is_neg_fs[c]) begin
                mag[c] = POS_MAX;
            end else if (in_data[c*W+W-1]) begin
                mag[c] = -in_data[c*W +: W];
            end else begin
                mag[c] = in_data[c*W +: W];
            end
        end
    end

    assign accept    = in_valid && (state_q == ACCUM);
    assign last_beat = accept && (cnt_q == {LOG2_WIN{1'b1}});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quiet_all_d = quiet_all_q;
        out_valid_d = out_valid_q;
        clip_acc_d  = clip_acc_q;
        clip_d      = clip_q;
        sum_d       = sum_q;
        run_peak_d  = run_peak_q;
        mean_d      = mean_q;
        peak_d      = peak_q;
        hold_d      = hold_q;
        noise_d     = noise_q;
        rel_d       = rel_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d       = cnt_q + 1'b1;
                    quiet_all_d = quiet_all_q & quiet_period;
                    clip_acc_d  = clip_acc_q | is_neg_fs;
                    for (int c = 0; c < NUM_CH; c++) begin
                        sum_d[c]      = sum_q[c] + SW'(mag[c]);
                        run_peak_d[c] = (mag[c] > run_peak_q[c]) ? mag[c] : run_peak_q[c];
                    end
                    if (last_beat) begin
                        state_d     = PUBLISH;
                        out_valid_d = 1'b1;
                        clip_d      = clip_acc_d;
                        for (int c = 0; c < NUM_CH; c++) begin
                            mean_d[c] = W'(sum_d[c] >> LOG2_WIN);
                            peak_d[c] = run_peak_d[c];
                            if (run_peak_d[c] >= hold_q[c] || rel_q[c] == HOLD_LAST) begin
                                hold_d[c] = run_peak_d[c];
                                rel_d[c]  = '0;
                            end else begin
                                rel_d[c]  = rel_q[c] + 1'b1;
                            end
                            if (quiet_all_d) begin
                                noise_d[c] = W'(sum_d[c] >> LOG2_WIN);
                            end
                        end
                    end
                end
            end
            PUBLISH: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    quiet_all_d = 1'b1;
                    clip_acc_d  = '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        sum_d[c]      = '0;
                        run_peak_d[c] = '0;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            quiet_all_q <= 1'b1;
            out_valid_q <= 1'b0;
            clip_acc_q  <= '0;
            clip_q      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c]      <= '0;
                run_peak_q[c] <= '0;
                mean_q[c]     <= '0;
                peak_q[c]     <= '0;
                hold_q[c]     <= '0;
                noise_q[c]    <= '0;
                rel_q[c]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quiet_all_q <= quiet_all_d;
            out_valid_q <= out_valid_d;
            clip_acc_q  <= clip_acc_d;
            clip_q      <= clip_d;
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c]      <= sum_d[c];
                run_peak_q[c] <= run_peak_d[c];
                mean_q[c]     <= mean_d[c];
                peak_q[c]     <= peak_d[c];
                hold_q[c]     <= hold_d[c];
                noise_q[c]    <= noise_d[c];
                rel_q[c]      <= rel_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            out_mean[c*W +: W]  = mean_q[c];
            out_peak[c*W +: W]  = peak_q[c];
            out_hold[c*W +: W]  = hold_q[c];
            out_noise[c*W +: W] = noise_q[c];
        end
    end

    assign out_clip  = clip_q;
    assign out_valid = out_valid_q;
    assign in_ready  = (state_q == ACCUM);

endmodule
